m_store_buffer: RTL and testbench
=================================

Name: m_store_buffer

Overview:
- Parametrised successor to the M-stage store-input path.
- Generates lane-aligned write data and byte enables for word/half/byte (and dword at DATA_W=64) stores, and raises AdES combinationally on the same cycle.
- Queues legal stores in a DEPTH-entry FIFO and drains them to the data bus over a valid/ready handshake, so the pipeline does not stall on slow bridge or timer writes.
- Provides a load-hazard flag for pending same-word stores.

Parameters:
- DATA_W, 32: bus data width; 32 or 64 only. NB = DATA_W/8 byte lanes; LSB = log2(NB).
- ADDR_W, 32: address width.
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- DM_TOP, 32'h0000_2FFF: last legal DM address (DM range starts at 0).
- TC0_BASE, 32'h0000_7F00: timer 0 base (12-byte window).
- TC1_BASE, 32'h0000_7F10: timer 1 base (12-byte window).
- INT_BASE, 32'h0000_7F20: interrupt-generator base (4-byte window).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- st_valid  in  1  M-stage store request
- st_addr  in  ADDR_W  byte address
- st_data  in  DATA_W  rt data, low-aligned
- st_op  in  2  00 word, 01 byte, 10 half, 11 dword
- req  in  1  interrupt/exception flush; store discarded
- addr_ov  in  1  address-calculation overflow from E stage
- st_ready  out  1  buffer can accept
- st_AdES  out  1  store address exception (combinational)
- bus_valid  out  1  head entry valid
- bus_addr  out  ADDR_W  head address, low LSB bits zero
- bus_wdata  out  DATA_W  head lane-placed data
- bus_byteen  out  NB  head byte enables
- bus_ready  in  1  bus accepts head
- ld_addr  in  ADDR_W  M-stage load address
- ld_hit  out  1  pending entry matches ld_addr's word
- count  out  log2(DEPTH)+1  occupancy
- empty  out  1  count==0

Behaviour:
- Lane placement:
  - Byte at lane addr[LSB-1:0]; half at lanes {addr[LSB-1:1],0}+0/1; word at lanes {addr[LSB-1:2],00}+0..3; dword on all lanes.
  - Unused lanes are zero.
  - byteen bit i is set exactly for the written lanes.
- st_AdES = st_valid & (any of the following), independent of st_ready and req:
  - misalign: half with addr[0]; word with addr[1:0]≠0; dword with addr[2:0]≠0.
  - st_op==11 when DATA_W==32.
  - Out of range: not in [0,DM_TOP], [TC0_BASE,+0xB], [TC1_BASE,+0xB], [INT_BASE,+3].
  - Any non-word op inside a timer window.
  - Any store to TC0_BASE+8..+B or TC1_BASE+8..+B (read-only count register).
  - addr_ov.
- Enqueue fires when st_valid & st_ready & !st_AdES & !req. The entry is written at the tail and the tail pointer advances modulo DEPTH.
- st_ready = !full. A full buffer never accepts, even when a dequeue occurs in the same cycle.
- Dequeue fires when bus_valid & bus_ready; the head pointer advances.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- bus_valid = !empty. bus_addr, bus_wdata and bus_byteen are driven from the head entry, held stable while bus_valid & !bus_ready, and are zero when empty.
- Latency: an accepted store appears on the bus in the next cycle if the buffer was empty.
- ld_hit: combinational OR over all valid entries of (entry word address == ld_addr word address). The head entry being dequeued this cycle still counts.
- Pointer wrap: pointers carry an extra MSB; full = (MSBs differ & rest equal).
- Reset (asynchronous, while low) clears:
  - pointers, count and all entry valid state to 0;
  - bus_valid = 0, bus_* = 0, empty = 1, ld_hit = 0.
  - Stores in flight are lost.
  - st_AdES remains purely combinational.

Optional Feature:
- STORE_MERGE_EN defined: if an enqueue-eligible store's word address equals the tail-most valid entry's word address, and that entry is not the head while bus_valid is asserted, the store merges into that entry.
  - Merged byteen = old | new.
  - Data lanes with new byteen set are overwritten.
  - count unchanged; st_ready is asserted even when full if a merge is possible.
- Undefined: no merging; every accepted store takes its own entry.

Test Plan:
- sb 0xAB at 0x0000_1003, DATA_W=32, bus_ready=1 -> next cycle bus_addr=0x1000, bus_wdata=0xAB00_0000, bus_byteen=1000, then empty=1.
- sh to 0x1001; sw to 0x7F08; sb to 0x7F04; sw to 0x3000 -> st_AdES=1 each cycle, count stays 0, bus_valid stays 0.
- bus_ready=0, 4 sw to 0x0,0x4,0x8,0xC (DEPTH=4) -> count=4, st_ready=0, 5th store stalled. Then bus_ready=1 -> drained in order 0x0..0xC over 4 cycles, bus data stable while stalled.
- Buffer holding 0x10 with ld_addr=0x12 -> ld_hit=1; ld_addr=0x14 -> ld_hit=0. req=1 with valid sw to 0x20 -> not enqueued.
- STORE_MERGE_EN, bus_ready=0, head sw 0x0, then sb 0x11@0x4, sb 0x22@0x5 -> count=2, entry1 byteen=0011, wdata=0x0000_2211.
- Assert reset with count=3 mid-drain -> count=0, bus_valid=0, empty=1 immediately; first store after release appears at the head.

Source files
------------

// File: rtl/m_store_buffer.sv
// M-stage store buffer: lane placement, AdES detection, DEPTH-entry write FIFO and load-hazard flag.
// Define STORE_MERGE_EN to let a store fold into the tail-most pending entry of the same bus word.
module m_store_buffer #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] DM_TOP   = ADDR_W'(32'h0000_2FFF),
    parameter logic [ADDR_W-1:0] TC0_BASE = ADDR_W'(32'h0000_7F00),
    parameter logic [ADDR_W-1:0] TC1_BASE = ADDR_W'(32'h0000_7F10),
    parameter logic [ADDR_W-1:0] INT_BASE = ADDR_W'(32'h0000_7F20)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      st_valid,
    input  logic [ADDR_W-1:0]         st_addr,
    input  logic [DATA_W-1:0]         st_data,
    input  logic [1:0]                st_op,
    input  logic                      req,
    input  logic                      addr_ov,
    output logic                      st_ready,
    output logic                      st_AdES,
    output logic                      bus_valid,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic [DATA_W/8-1:0]       bus_byteen,
    input  logic                      bus_ready,
    input  logic [ADDR_W-1:0]         ld_addr,
    output logic                      ld_hit,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int NB   = DATA_W / 8;
    localparam int LSB  = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);
    localparam int WA_W = ADDR_W - LSB;

    localparam logic [ADDR_W-1:0] TC0_RO  = TC0_BASE + ADDR_W'(8);
    localparam logic [ADDR_W-1:0] TC0_END = TC0_BASE + ADDR_W'(11);
    localparam logic [ADDR_W-1:0] TC1_RO  = TC1_BASE + ADDR_W'(8);
    localparam logic [ADDR_W-1:0] TC1_END = TC1_BASE + ADDR_W'(11);
    localparam logic [ADDR_W-1:0] INT_END = INT_BASE + ADDR_W'(3);
    localparam logic [PW:0]       PTR_ONE = (PW+1)'(1);
    localparam bit                NO_DWORD = (DATA_W == 32);

    // FIFO storage: control state is reset, payload is not
    logic [WA_W-1:0]   r_addr   [DEPTH];
    logic [DATA_W-1:0] r_wdata  [DEPTH];
    logic [NB-1:0]     r_byteen [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW:0]       r_head;
    logic [PW:0]       r_tail;

    logic [PW-1:0]     w_head_idx;
    logic [PW-1:0]     w_tail_idx;
    logic [PW-1:0]     w_last_idx;
    logic              w_empty;
    logic              w_full;
    logic              w_enq;
    logic              w_deq;
    logic              w_merge;
    logic [WA_W-1:0]   w_st_word;

    logic [LSB-1:0]    w_off;
    logic [NB-1:0]     w_lane_be;
    logic [DATA_W-1:0] w_lane_data;
    logic [DATA_W-1:0] w_be_mask;

    logic              w_misalign;
    logic              w_dword_bad;
    logic              w_in_dm;
    logic              w_in_tc0;
    logic              w_in_tc1;
    logic              w_in_int;
    logic              w_in_range;
    logic              w_tc_subword;
    logic              w_ro;
    logic              w_hit;
    logic              w_unused_ld;

    assign w_head_idx = r_head[PW-1:0];
    assign w_tail_idx = r_tail[PW-1:0];
    assign w_last_idx = w_tail_idx - PW'(1);
    assign w_st_word  = st_addr[ADDR_W-1:LSB];
    assign w_unused_ld = ^ld_addr[LSB-1:0];

    assign count   = r_tail - r_head;
    assign w_empty = (r_tail == r_head);
    assign w_full  = (r_tail[PW] != r_head[PW]) && (r_tail[PW-1:0] == r_head[PW-1:0]);
    assign empty   = w_empty;

    // Lane placement: the offset is the access-aligned lane index within the bus word
    always_comb begin
        w_off       = '0;
        w_lane_be   = '0;
        w_lane_data = '0;
        case (st_op)
            2'b01: begin
                w_off       = st_addr[LSB-1:0];
                w_lane_be   = NB'(1) << w_off;
                w_lane_data = DATA_W'(st_data[7:0]) << {w_off, 3'b000};
            end
            2'b10: begin
                w_off       = st_addr[LSB-1:0] & ~LSB'(1);
                w_lane_be   = NB'(3) << w_off;
                w_lane_data = DATA_W'(st_data[15:0]) << {w_off, 3'b000};
            end
            2'b00: begin
                w_off       = st_addr[LSB-1:0] & ~LSB'(3);
                w_lane_be   = NB'(15) << w_off;
                w_lane_data = DATA_W'(st_data[31:0]) << {w_off, 3'b000};
            end
            default: begin
                w_lane_be   = '1;
                w_lane_data = st_data;
            end
        endcase
    end

    always_comb begin
        w_be_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_be_mask[8*i +: 8] = {8{w_lane_be[i]}};
        end
    end

    always_comb begin
        case (st_op)
            2'b10:   w_misalign = st_addr[0];
            2'b00:   w_misalign = |st_addr[1:0];
            2'b11:   w_misalign = |st_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_dword_bad  = NO_DWORD && (st_op == 2'b11);
    assign w_in_dm      = (st_addr <= DM_TOP);
    assign w_in_tc0     = (st_addr >= TC0_BASE) && (st_addr <= TC0_END);
    assign w_in_tc1     = (st_addr >= TC1_BASE) && (st_addr <= TC1_END);
    assign w_in_int     = (st_addr >= INT_BASE) && (st_addr <= INT_END);
    assign w_in_range   = w_in_dm || w_in_tc0 || w_in_tc1 || w_in_int;
    assign w_tc_subword = (w_in_tc0 || w_in_tc1) && (st_op != 2'b00);
    // Timer count registers are read-only
    assign w_ro         = ((st_addr >= TC0_RO) && (st_addr <= TC0_END)) ||
                          ((st_addr >= TC1_RO) && (st_addr <= TC1_END));

    assign st_AdES = st_valid & (w_misalign | w_dword_bad | ~w_in_range |
                                 w_tc_subword | w_ro | addr_ov);

`ifdef STORE_MERGE_EN
    logic w_merge_hit;

    // The tail-most entry is the head exactly when one entry is pending
    assign w_merge_hit = st_valid & ~st_AdES & ~w_empty & (count != PTR_ONE) &
                         (r_addr[w_last_idx] == w_st_word);
    assign w_merge     = w_merge_hit & ~req;
    assign st_ready    = ~w_full | w_merge_hit;
`else
    assign w_merge     = 1'b0;
    assign st_ready    = ~w_full;
`endif

    assign w_enq = st_valid & st_ready & ~st_AdES & ~req & ~w_merge;
    assign w_deq = ~w_empty & bus_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
        end else begin
            if (w_deq) begin
                r_head             <= r_head + PTR_ONE;
                r_vld[w_head_idx]  <= 1'b0;
            end
            if (w_enq) begin
                r_tail             <= r_tail + PTR_ONE;
                r_vld[w_tail_idx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[w_tail_idx]   <= w_st_word;
            r_wdata[w_tail_idx]  <= w_lane_data;
            r_byteen[w_tail_idx] <= w_lane_be;
        end else if (w_merge) begin
            r_wdata[w_last_idx]  <= (r_wdata[w_last_idx] & ~w_be_mask) | (w_lane_data & w_be_mask);
            r_byteen[w_last_idx] <= r_byteen[w_last_idx] | w_lane_be;
        end
    end

    assign bus_valid  = ~w_empty;
    assign bus_addr   = w_empty ? '0 : {r_addr[w_head_idx], {LSB{1'b0}}};
    assign bus_wdata  = w_empty ? '0 : r_wdata[w_head_idx];
    assign bus_byteen = w_empty ? '0 : r_byteen[w_head_idx];

    // A head entry being drained this cycle still counts as a hazard
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == ld_addr[ADDR_W-1:LSB])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_hit = w_hit;

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed-vector bench for m_store_buffer at DATA_W=32, DEPTH=4.
module tb_m_store_buffer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              st_valid, req, addr_ov, bus_ready;
    logic [ADDR_W-1:0] st_addr, ld_addr;
    logic [DATA_W-1:0] st_data;
    logic [1:0]        st_op;
    logic              st_ready, st_AdES, bus_valid, ld_hit, empty;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_byteen;
    logic [2:0]        count;

    int n_vec = 0;
    int n_bad = 0;

    m_store_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
        .st_data(st_data), .st_op(st_op), .req(req), .addr_ov(addr_ov),
        .st_ready(st_ready), .st_AdES(st_AdES), .bus_valid(bus_valid),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
        .bus_ready(bus_ready), .ld_addr(ld_addr), .ld_hit(ld_hit),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_op = 2'b00;
        req = 1'b0; addr_ov = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_op = op; st_addr = a; st_data = d;
    endtask

    task automatic test_reset();
        idle_inputs(); bus_ready = 1'b0; ld_addr = '0;
        #3;
        n_vec++;
        if ({bus_valid, empty, ld_hit, st_ready} !== 4'b0101) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0101", {bus_valid, empty, ld_hit, st_ready});
        end
        n_vec++;
        if ({count, bus_addr, bus_wdata, bus_byteen} !== '0) begin
            n_bad++; $display("FAIL reset_bus: count=%0d addr=%h data=%h be=%b want all zero", count, bus_addr, bus_wdata, bus_byteen);
        end
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_lane_placement();
        logic [1:0]  ops [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [31:0] adr [6] = '{32'h1003, 32'h1001, 32'h1002, 32'h2FFC, 32'h7F20, 32'h7F14};
        logic [31:0] dat [6] = '{32'hAB, 32'h1234_5678, 32'hCAFE_BEEF, 32'h1234, 32'hDEAD_BEEF, 32'h0BAD_F00D};
        logic [31:0] ea  [6] = '{32'h1000, 32'h1000, 32'h1000, 32'h2FFC, 32'h7F20, 32'h7F14};
        logic [31:0] ed  [6] = '{32'hAB00_0000, 32'h0000_7800, 32'hBEEF_0000, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0BAD_F00D};
        logic [3:0]  eb  [6] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1111};
        bus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_st(ops[i], adr[i], dat[i]);
            @(negedge clk);
            n_vec++;
            if ({st_AdES, st_ready} !== 2'b01) begin
                n_bad++; $display("FAIL lane_accept[%0d]: ades/ready=%b want 01", i, {st_AdES, st_ready});
            end
            next_cycle();
            idle_inputs();
            @(negedge clk);
            n_vec++;
            if ({bus_valid, bus_addr, bus_wdata, bus_byteen, count} !== {1'b1, ea[i], ed[i], eb[i], 3'd1}) begin
                n_bad++; $display("FAIL lane_bus[%0d]: v=%b a=%h d=%h be=%b cnt=%0d want 1 %h %h %b 1",
                                  i, bus_valid, bus_addr, bus_wdata, bus_byteen, count, ea[i], ed[i], eb[i]);
            end
            next_cycle();
            @(negedge clk);
            n_vec++;
            if ({empty, bus_valid, bus_wdata} !== {1'b1, 1'b0, 32'h0}) begin
                n_bad++; $display("FAIL lane_drained[%0d]: empty=%b valid=%b data=%h want 1 0 0", i, empty, bus_valid, bus_wdata);
            end
            next_cycle();
        end
    endtask

    task automatic test_ades();
        logic [1:0]  ops [7] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00};
        logic [31:0] adr [7] = '{32'h1001, 32'h7F08, 32'h7F04, 32'h3000, 32'h0000, 32'h7F24, 32'h7F18};
        bus_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 7) drive_st(ops[i], adr[i], 32'h5A5A_5A5A);
            else begin
                drive_st(2'b00, 32'h100, 32'h5A5A_5A5A);
                addr_ov = 1'b1;
            end
            @(negedge clk);
            n_vec++;
            if (st_AdES !== 1'b1) begin
                n_bad++; $display("FAIL ades[%0d]: st_AdES=%b want 1", i, st_AdES);
            end
            next_cycle();
            idle_inputs();
            @(negedge clk);
            n_vec++;
            if ({count, bus_valid} !== 4'b0000) begin
                n_bad++; $display("FAIL ades_noenq[%0d]: count=%0d valid=%b want 0 0", i, count, bus_valid);
            end
            next_cycle();
        end
        st_addr = 32'h1001; st_op = 2'b10;
        @(negedge clk);
        n_vec++;
        if (st_AdES !== 1'b0) begin
            n_bad++; $display("FAIL ades_novalid: st_AdES=%b want 0", st_AdES);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_fill_drain();
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_st(2'b00, 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            next_cycle();
        end
        drive_st(2'b00, 32'h10, 32'h5555_5555);
        @(negedge clk);
        n_vec++;
        if ({count, st_ready} !== {3'd4, 1'b0}) begin
            n_bad++; $display("FAIL full: count=%0d ready=%b want 4 0", count, st_ready);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if ({count, bus_addr, bus_wdata, bus_byteen} !== {3'd4, 32'h0, 32'h1111_1111, 4'b1111}) begin
            n_bad++; $display("FAIL stall_hold: count=%0d a=%h d=%h be=%b want 4 0 11111111 1111", count, bus_addr, bus_wdata, bus_byteen);
        end
        next_cycle();
        bus_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (st_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_deq_ready: st_ready=%b want 0", st_ready);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (count !== 3'd3) begin
            n_bad++; $display("FAIL full_deq_count: count=%0d want 3", count);
        end
        for (int i = 1; i < 4; i++) begin
            n_vec++;
            if ({bus_valid, bus_addr, bus_wdata} !== {1'b1, 32'(4 * i), 32'h1111_1111 * 32'(i + 1)}) begin
                n_bad++; $display("FAIL drain[%0d]: v=%b a=%h d=%h want 1 %h %h", i, bus_valid, bus_addr, bus_wdata,
                                  32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            end
            next_cycle();
            @(negedge clk);
        end
        n_vec++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            n_bad++; $display("FAIL drain_empty: empty=%b count=%0d want 1 0", empty, count);
        end
        next_cycle();
    endtask

    task automatic test_ld_hit_req();
        bus_ready = 1'b0;
        drive_st(2'b00, 32'h10, 32'h77);
        next_cycle();
        idle_inputs();
        ld_addr = 32'h12;
        @(negedge clk);
        n_vec++;
        if (ld_hit !== 1'b1) begin
            n_bad++; $display("FAIL ld_hit_same: ld_hit=%b want 1", ld_hit);
        end
        ld_addr = 32'h14;
        #1;
        n_vec++;
        if (ld_hit !== 1'b0) begin
            n_bad++; $display("FAIL ld_hit_other: ld_hit=%b want 0", ld_hit);
        end
        next_cycle();
        drive_st(2'b00, 32'h20, 32'h99);
        req = 1'b1;
        next_cycle();
        idle_inputs();
        ld_addr = 32'h20;
        @(negedge clk);
        n_vec++;
        if ({count, ld_hit} !== {3'd1, 1'b0}) begin
            n_bad++; $display("FAIL req_flush: count=%0d ld_hit=%b want 1 0", count, ld_hit);
        end
        next_cycle();
        ld_addr = 32'h10;
        bus_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ld_hit !== 1'b1) begin
            n_bad++; $display("FAIL ld_hit_deq: ld_hit=%b want 1", ld_hit);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if ({empty, ld_hit} !== 2'b10) begin
            n_bad++; $display("FAIL ld_hit_after: empty/ld_hit=%b want 10", {empty, ld_hit});
        end
        next_cycle();
    endtask

    task automatic test_merge();
        logic [2:0]  exp_cnt;
        logic [31:0] exp_d1;
        logic [3:0]  exp_b1;
`ifdef STORE_MERGE_EN
        exp_cnt = 3'd2; exp_d1 = 32'h0000_2211; exp_b1 = 4'b0011;
`else
        exp_cnt = 3'd3; exp_d1 = 32'h0000_0011; exp_b1 = 4'b0001;
`endif
        bus_ready = 1'b0;
        drive_st(2'b00, 32'h0, 32'hAAAA_AAAA);
        next_cycle();
        drive_st(2'b01, 32'h4, 32'h11);
        next_cycle();
        drive_st(2'b01, 32'h5, 32'h22);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (count !== exp_cnt) begin
            n_bad++; $display("FAIL merge_count: count=%0d want %0d", count, exp_cnt);
        end
        next_cycle();
        bus_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus_addr, bus_wdata, bus_byteen} !== {32'h0, 32'hAAAA_AAAA, 4'b1111}) begin
            n_bad++; $display("FAIL merge_head: a=%h d=%h be=%b want 0 aaaaaaaa 1111", bus_addr, bus_wdata, bus_byteen);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if ({bus_addr, bus_wdata, bus_byteen} !== {32'h4, exp_d1, exp_b1}) begin
            n_bad++; $display("FAIL merge_entry1: a=%h d=%h be=%b want 4 %h %b", bus_addr, bus_wdata, bus_byteen, exp_d1, exp_b1);
        end
        next_cycle();
`ifndef STORE_MERGE_EN
        @(negedge clk);
        n_vec++;
        if ({bus_addr, bus_wdata, bus_byteen} !== {32'h4, 32'h0000_2200, 4'b0010}) begin
            n_bad++; $display("FAIL nomerge_entry2: a=%h d=%h be=%b want 4 00002200 0010", bus_addr, bus_wdata, bus_byteen);
        end
        next_cycle();
`endif
        @(negedge clk);
        n_vec++;
        if (empty !== 1'b1) begin
            n_bad++; $display("FAIL merge_empty: empty=%b want 1", empty);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_st(2'b00, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            next_cycle();
        end
        idle_inputs();
        bus_ready = 1'b1;
        ld_addr = 32'h104;
        next_cycle();
        n_vec++;
        if (count !== 3'd3) begin
            n_bad++; $display("FAIL mid_count: count=%0d want 3", count);
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({count, bus_valid, empty, ld_hit} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL async_reset: count=%0d valid=%b empty=%b ld_hit=%b want 0 0 1 0", count, bus_valid, empty, ld_hit);
        end
        n_vec++;
        if ({bus_addr, bus_wdata, bus_byteen} !== '0) begin
            n_bad++; $display("FAIL async_reset_bus: a=%h d=%h be=%b want zero", bus_addr, bus_wdata, bus_byteen);
        end
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        bus_ready = 1'b0;
        drive_st(2'b00, 32'h40, 32'h55);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if ({count, bus_addr, bus_wdata, bus_byteen} !== {3'd1, 32'h40, 32'h55, 4'b1111}) begin
            n_bad++; $display("FAIL post_reset_head: count=%0d a=%h d=%h be=%b want 1 40 55 1111", count, bus_addr, bus_wdata, bus_byteen);
        end
        bus_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (empty !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_drain: empty=%b want 1", empty);
        end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lane_placement();
        test_ades();
        test_fill_drain();
        test_ld_hit_req();
        test_merge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
